// File: rtl/mkmif_pkg.sv
// Shared definitions for the MKM interface: arbiter FSM encoding, default
// widths, the SPI command bytes the core issues, and the round-robin pick rule.
package mkmif_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  // SPI serial SRAM command bytes driven by the core.
  localparam logic [7:0] SPI_WRSR_CMD  = 8'h01;
  localparam logic [7:0] SPI_WRITE_CMD = 8'h02;
  localparam logic [7:0] SPI_READ_CMD  = 8'h03;
  localparam logic [7:0] SPI_RDSR_CMD  = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } arb_state_t;

  // Two-way round robin: a lone request wins outright; on a tie the
  // requester that did not win last time is chosen.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_grant);
    logic pick;
    if (req0 && req1) begin
      pick = ~last_grant;
    end else begin
      pick = req1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mkmif_rr2.sv
// Two-requester round-robin grant selector (purely combinational).
import mkmif_pkg::*;

module mkmif_rr2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant,
  output logic grant_vld
);

  // Grant index follows the shared pick rule; valid whenever anyone asks.
  always_comb begin
    grant_vld = req0 | req1;
    grant     = rr_pick(req0, req1, last_grant);
  end

endmodule

// File: rtl/mkmif_arbiter.sv
// Round-robin arbiter letting two masters share one MKM interface core.
// Requests are latched in IDLE, issued as a single read/write strobe once the
// core is ready, and completed with a one-cycle ack to the winner.
// Optional build macro MKMIF_ARB_PROTECT_EN: requester 1 accesses at or above
// PROT_LIMIT are rejected with an error ack and never reach the core.
import mkmif_pkg::*;

module mkmif_arbiter #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] PROT_LIMIT = 16'h1000
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ack,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_error,

  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ack,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_error,

  input  logic              core_ready,
  output logic              core_read_op,
  output logic              core_write_op,
  output logic [ADDR_W-1:0] core_addr,
  output logic [DATA_W-1:0] core_write_data,
  input  logic [DATA_W-1:0] core_read_data,

  output logic              busy
);

`ifdef MKMIF_ARB_PROTECT_EN
  localparam bit PROTECT = 1'b1;
`else
  localparam bit PROTECT = 1'b0;
`endif

  arb_state_t          state;
  arb_state_t          state_nxt;

  logic                grant;
  logic                grant_vld;
  logic                last_grant;

  logic                grant_r;
  logic                we_r;
  logic                reject_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   rdata0_r;
  logic [DATA_W-1:0]   rdata1_r;

  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                reject_now;
  logic                issue_fire;
  logic                take_req;
  logic                capture_rd;

  mkmif_rr2 u_rr2 (
    .req0       (req0_valid),
    .req1       (req1_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_vld  (grant_vld)
  );

  // Request selection and protection check for the requester being granted.
  always_comb begin
    sel_we     = grant ? req1_we    : req0_we;
    sel_addr   = grant ? req1_addr  : req0_addr;
    sel_wdata  = grant ? req1_wdata : req0_wdata;
    reject_now = PROTECT && grant && (req1_addr >= PROT_LIMIT);
    take_req   = (state == ST_IDLE) && grant_vld;
    issue_fire = (state == ST_ISSUE) && core_ready;
    capture_rd = (state == ST_WAIT_DONE) && core_ready && !we_r;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and core/requester handshake outputs.
  always_comb begin
    state_nxt     = state;
    core_read_op  = 1'b0;
    core_write_op = 1'b0;
    req0_ack      = 1'b0;
    req1_ack      = 1'b0;
    req1_error    = 1'b0;
    busy          = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (grant_vld) begin
          state_nxt = reject_now ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The core only samples a strobe while ready, so wait out its init.
        if (core_ready) begin
          core_write_op = we_r;
          core_read_op  = ~we_r;
          state_nxt     = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!core_ready) begin
          state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (core_ready) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        req0_ack   = ~grant_r;
        req1_ack   = grant_r;
        req1_error = grant_r & reject_r;
        state_nxt  = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Requester 0 is never restricted.
  assign req0_error      = 1'b0;
  assign core_addr       = addr_r;
  assign core_write_data = wdata_r;
  assign req0_rdata      = rdata0_r;
  assign req1_rdata      = rdata1_r;

  // Latch the granted request in IDLE; rotate priority even on rejects.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      grant_r    <= 1'b0;
      we_r       <= 1'b0;
      reject_r   <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
    end else if (take_req) begin
      last_grant <= grant;
      grant_r    <= grant;
      we_r       <= sel_we;
      reject_r   <= reject_now;
      addr_r     <= sel_addr;
      wdata_r    <= sel_wdata;
    end
  end

  // Read data is captured on the cycle the core reports completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0_r <= '0;
      rdata1_r <= '0;
    end else if (capture_rd) begin
      if (grant_r) begin
        rdata1_r <= core_read_data;
      end else begin
        rdata0_r <= core_read_data;
      end
    end
  end

endmodule

// File: tb/tb_mkmif_arbiter.sv
// Directed bench for mkmif_arbiter with a small behavioural core model.
module tb_mkmif_arbiter;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int CORE_LAT = 4;
  localparam int TIMEOUT  = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              req0_valid, req0_we, req0_ack, req0_error;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata, req0_rdata;
  logic              req1_valid, req1_we, req1_ack, req1_error;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata, req1_rdata;
  logic              core_ready = 1'b0;
  logic              core_read_op, core_write_op, busy;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_write_data;
  logic [DATA_W-1:0] core_read_data = '0;

  int checks = 0;
  int errors = 0;

  bit                core_hold = 1'b1;
  logic [DATA_W-1:0] rd_value  = '0;
  int                lat_cnt   = 0;
  logic [ADDR_W-1:0] cap_addr  = '0;
  logic [DATA_W-1:0] cap_wdata = '0;
  int                hold_viol = 0;
  int                hyg_viol  = 0;
  int                rd_strobes = 0;
  int                wr_strobes = 0;
  int                ack0_cnt  = 0;
  int                ack1_cnt  = 0;

  mkmif_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROT_LIMIT(16'h1000)) dut (
    .clk             (clk),
    .reset           (reset),
    .req0_valid      (req0_valid),
    .req0_we         (req0_we),
    .req0_addr       (req0_addr),
    .req0_wdata      (req0_wdata),
    .req0_ack        (req0_ack),
    .req0_rdata      (req0_rdata),
    .req0_error      (req0_error),
    .req1_valid      (req1_valid),
    .req1_we         (req1_we),
    .req1_addr       (req1_addr),
    .req1_wdata      (req1_wdata),
    .req1_ack        (req1_ack),
    .req1_rdata      (req1_rdata),
    .req1_error      (req1_error),
    .core_ready      (core_ready),
    .core_read_op    (core_read_op),
    .core_write_op   (core_write_op),
    .core_addr       (core_addr),
    .core_write_data (core_write_data),
    .core_read_data  (core_read_data),
    .busy            (busy)
  );

  // Core model: accept a strobe while ready, drop ready next cycle, finish
  // CORE_LAT cycles later with read data valid on the rising-ready cycle.
  always @(posedge clk) begin
    if (core_hold) begin
      core_ready <= 1'b0;
      lat_cnt    <= 0;
    end else if (lat_cnt > 0) begin
      if (busy && (core_addr !== cap_addr || core_write_data !== cap_wdata))
        hold_viol <= hold_viol + 1;
      if (lat_cnt == 1) begin
        core_ready     <= 1'b1;
        core_read_data <= rd_value;
      end
      lat_cnt <= lat_cnt - 1;
    end else if (core_ready && (core_read_op || core_write_op)) begin
      core_ready <= 1'b0;
      lat_cnt    <= CORE_LAT;
      cap_addr   <= core_addr;
      cap_wdata  <= core_write_data;
    end else begin
      core_ready <= 1'b1;
    end
  end

  // Protocol monitor on the falling edge: strobe/ack hygiene and counts.
  always @(negedge clk) begin
    hyg_viol <= hyg_viol
              + int'(core_read_op && core_write_op)
              + int'((core_read_op || core_write_op) && !core_ready)
              + int'(!busy && (core_read_op || core_write_op || req0_ack || req1_ack))
              + int'(req0_ack && req1_ack);
    rd_strobes <= rd_strobes + int'(core_read_op);
    wr_strobes <= wr_strobes + int'(core_write_op);
    ack0_cnt   <= ack0_cnt + int'(req0_ack);
    ack1_cnt   <= ack1_cnt + int'(req1_ack);
  end

  typedef struct {
    string             name;
    int                who;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdv;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_core;
    logic              exp_err;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input string name, input int who, input logic we,
                              input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                              input logic [DATA_W-1:0] rdv, input logic [DATA_W-1:0] exp_rdata,
                              input logic exp_core, input logic exp_err);
    vec_t v;
    v.name = name; v.who = who; v.we = we; v.addr = addr; v.wdata = wdata;
    v.rdv = rdv; v.exp_rdata = exp_rdata; v.exp_core = exp_core; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One single-requester transaction: drive, wait for ack, check results.
  task automatic run_txn(input vec_t v);
    int rd0 = rd_strobes;
    int wr0 = wr_strobes;
    bit seen = 1'b0;
    rd_value = v.rdv;
    if (v.who == 0) begin
      req0_we = v.we; req0_addr = v.addr; req0_wdata = v.wdata; req0_valid = 1'b1;
    end else begin
      req1_we = v.we; req1_addr = v.addr; req1_wdata = v.wdata; req1_valid = 1'b1;
    end
    for (int c = 0; c < TIMEOUT; c++) begin
      cycle();
      if ((v.who == 0) ? req0_ack : req1_ack) begin
        seen = 1'b1;
        break;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({v.name, " ack"}, 32'(seen), 32'd1);
    if (seen) begin
      check({v.name, " rdata"}, (v.who == 0) ? req0_rdata : req1_rdata, v.exp_rdata);
      check({v.name, " error"}, 32'((v.who == 0) ? req0_error : req1_error), 32'(v.exp_err));
      check({v.name, " other ack"}, 32'((v.who == 0) ? req1_ack : req0_ack), 32'd0);
    end
    check({v.name, " read strobes"}, 32'(rd_strobes - rd0), (v.exp_core && !v.we) ? 32'd1 : 32'd0);
    check({v.name, " write strobes"}, 32'(wr_strobes - wr0), (v.exp_core && v.we) ? 32'd1 : 32'd0);
    if (v.exp_core) begin
      check({v.name, " core addr"}, 32'(cap_addr), 32'(v.addr));
      if (v.we) check({v.name, " core wdata"}, cap_wdata, v.wdata);
    end
    cycle();
    check({v.name, " ack one cycle"}, 32'(req0_ack | req1_ack), 32'd0);
  endtask

  initial begin
    int a0, a1, rd0;
    bit seen;
    int who;

    vecs[0] = mk("wr0_0004", 0, 1'b1, 16'h0004, 32'h01234567, 32'h0, 32'hdeadbeef, 1'b1, 1'b0);
    vecs[1] = mk("rd1_0020", 1, 1'b0, 16'h0020, 32'h0, 32'hcafef00d, 32'hcafef00d, 1'b1, 1'b0);
    vecs[2] = mk("rd0_0030", 0, 1'b0, 16'h0030, 32'h0, 32'h11112222, 32'h11112222, 1'b1, 1'b0);
    vecs[3] = mk("wr1_0fff", 1, 1'b1, 16'h0fff, 32'ha5a5a5a5, 32'h0, 32'hcafef00d, 1'b1, 1'b0);
    vecs[4] = mk("rd1_0fff", 1, 1'b0, 16'h0fff, 32'h0, 32'h55aa55aa, 32'h55aa55aa, 1'b1, 1'b0);
`ifdef MKMIF_ARB_PROTECT_EN
    vecs[5] = mk("rd1_1000", 1, 1'b0, 16'h1000, 32'h0, 32'h77778888, 32'h55aa55aa, 1'b0, 1'b1);
    vecs[6] = mk("wr1_ffff", 1, 1'b1, 16'hffff, 32'h12121212, 32'h0, 32'h55aa55aa, 1'b0, 1'b1);
`else
    vecs[5] = mk("rd1_1000", 1, 1'b0, 16'h1000, 32'h0, 32'h77778888, 32'h77778888, 1'b1, 1'b0);
    vecs[6] = mk("wr1_ffff", 1, 1'b1, 16'hffff, 32'h12121212, 32'h0, 32'h77778888, 1'b1, 1'b0);
`endif
    vecs[7] = mk("rd0_1000", 0, 1'b0, 16'h1000, 32'h0, 32'h9999aaaa, 32'h9999aaaa, 1'b1, 1'b0);

    reset = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    repeat (3) cycle();
    reset = 1'b0;

    // Reset state.
    check("rst req0_ack", 32'(req0_ack), 32'd0);
    check("rst req1_ack", 32'(req1_ack), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst strobes", 32'({core_read_op, core_write_op}), 32'd0);
    check("rst core_addr", 32'(core_addr), 32'd0);
    check("rst core_wdata", core_write_data, 32'd0);
    check("rst rdata0", req0_rdata, 32'd0);
    check("rst rdata1", req1_rdata, 32'd0);
    check("rst errors", 32'({req0_error, req1_error}), 32'd0);

    // Core still initialising: request must wait without any strobe.
    req0_we = 1'b0; req0_addr = 16'h0010; req0_valid = 1'b1;
    repeat (20) cycle();
    check("init no strobe", 32'(rd_strobes + wr_strobes), 32'd0);
    check("init busy", 32'(busy), 32'd1);
    check("init no ack", 32'(ack0_cnt), 32'd0);
    core_hold = 1'b0;
    run_txn(mk("rd0_0010", 0, 1'b0, 16'h0010, 32'h0, 32'hdeadbeef, 32'hdeadbeef, 1'b1, 1'b0));

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Reset while the core transfer is in flight.
    a0 = ack0_cnt;
    rd0 = rd_strobes;
    rd_value = 32'h0bad0bad;
    req0_we = 1'b0; req0_addr = 16'h0070; req0_valid = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < TIMEOUT; c++) begin
      cycle();
      if (rd_strobes != rd0) begin
        seen = 1'b1;
        break;
      end
    end
    check("midrst strobe seen", 32'(seen), 32'd1);
    cycle();
    reset = 1'b1;
    req0_valid = 1'b0;
    cycle();
    reset = 1'b0;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst acks", 32'({req0_ack, req1_ack}), 32'd0);
    check("midrst strobes", 32'({core_read_op, core_write_op}), 32'd0);
    check("midrst core_addr", 32'(core_addr), 32'd0);
    check("midrst rdata0", req0_rdata, 32'd0);
    repeat (12) cycle();
    check("midrst no late ack", 32'(ack0_cnt - a0), 32'd0);
    check("midrst rdata0 kept", req0_rdata, 32'd0);
    run_txn(mk("rd1_0060", 1, 1'b0, 16'h0060, 32'h0, 32'h0badcafe, 32'h0badcafe, 1'b1, 1'b0));

    // Both requesters held: grants must alternate starting with requester 0.
    a0 = ack0_cnt;
    a1 = ack1_cnt;
    req0_we = 1'b0; req0_addr = 16'h0040;
    req1_we = 1'b0; req1_addr = 16'h0050;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rd_value = 32'h30000000 + 32'(k);
      seen = 1'b0;
      for (int c = 0; c < TIMEOUT; c++) begin
        cycle();
        if (req0_ack || req1_ack) begin
          seen = 1'b1;
          break;
        end
      end
      if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      check($sformatf("rr%0d ack", k), 32'(seen), 32'd1);
      who = req1_ack ? 1 : 0;
      check($sformatf("rr%0d grant", k), 32'(who), 32'(k % 2));
      check($sformatf("rr%0d rdata", k), (who == 0) ? req0_rdata : req1_rdata,
            32'h30000000 + 32'(k));
      check($sformatf("rr%0d core addr", k), 32'(cap_addr),
            (k % 2 == 0) ? 32'h0040 : 32'h0050);
      cycle();
    end
    repeat (5) cycle();
    check("rr acks req0", 32'(ack0_cnt - a0), 32'd2);
    check("rr acks req1", 32'(ack1_cnt - a1), 32'd2);

    check("strobe hygiene", 32'(hyg_viol), 32'd0);
    check("addr/data hold", 32'(hold_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
